// File: rtl/wb_spi_master.sv
// Wishbone classic slave SPI master: mode 0, 8-bit MSB-first frames, manual chip selects.
// Optional transfer-done interrupt (irq_o, STATUS.IE) is built when WB_SPI_MASTER_IRQ_EN is defined.
//
// state | meaning
// IDLE  | no transfer; SCK low, MOSI holds the last bit sent
// LOW   | SCK low half-period; MISO sampled as SCK rises on exit
// HIGH  | SCK high half-period; next MOSI bit driven as SCK falls on exit
module wb_spi_master #(
    parameter int unsigned DIV_RESET = 11,
    parameter int unsigned NUM_CS    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic              spi_sck_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic [NUM_CS-1:0] spi_cs_n_o
`ifdef WB_SPI_MASTER_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam logic [7:0] DIV_RST = DIV_RESET[7:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        div_q;
    logic [7:0]        divcnt_q, divcnt_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_q;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              done_q;
    logic              ovr_q;
    logic              ie_q;
    logic [NUM_CS-1:0] cs_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic [31:0]       rd_data;

    logic bus_access, bus_wr, bus_rd;
    logic busy, busy_eff, tc, finish, start;

    logic unused_ok;
    assign unused_ok = ^{wb_sel_i[3:1], wb_dat_i};

    assign bus_access = wb_cyc_i & wb_stb_i & ~ack_q;
    assign bus_wr     = bus_access & wb_we_i & wb_sel_i[0];
    assign bus_rd     = bus_access & ~wb_we_i;

    assign busy   = (state_q != ST_IDLE);
    assign tc     = (divcnt_q == 8'd0);
    assign finish = (state_q == ST_HIGH) && tc && (bitcnt_q == 3'd7);
    // The last edge of a transfer already counts as idle, so a DATA write there starts the next one.
    assign busy_eff = busy & ~finish;
    assign start    = bus_wr && (wb_adr_i == 2'd0) && !busy_eff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            divcnt_q <= '0;
            bitcnt_q <= '0;
            tx_q     <= '0;
            rx_sh_q  <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            divcnt_q <= divcnt_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            rx_sh_q  <= rx_sh_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOW;
            ST_LOW:  if (tc) state_d = ST_HIGH;
            ST_HIGH: begin
                if (tc) begin
                    if (bitcnt_q != 3'd7) state_d = ST_LOW;
                    else if (start)       state_d = ST_LOW;
                    else                  state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        divcnt_d = divcnt_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        rx_sh_d  = rx_sh_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        if (start) begin
            sck_d    = 1'b0;
            mosi_d   = wb_dat_i[7];
            tx_d     = wb_dat_i[7:0];
            bitcnt_d = 3'd0;
            divcnt_d = div_q;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (tc) begin
                        sck_d    = 1'b1;
                        rx_sh_d  = {rx_sh_q[6:0], spi_miso_i};
                        divcnt_d = div_q;
                    end else begin
                        divcnt_d = divcnt_q - 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        sck_d    = 1'b0;
                        divcnt_d = div_q;
                        if (bitcnt_q != 3'd7) begin
                            bitcnt_d = bitcnt_q + 3'd1;
                            tx_d     = {tx_q[6:0], 1'b0};
                            mosi_d   = tx_q[6];
                        end
                    end else begin
                        divcnt_d = divcnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            2'd0: rd_data = {24'd0, rx_q};
            2'd1: rd_data = {23'd0, ie_q, 5'd0, ovr_q, done_q, busy};
            2'd2: rd_data = {24'd0, div_q};
            2'd3: rd_data = 32'(cs_q);
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            div_q  <= DIV_RST;
            cs_q   <= '0;
            rx_q   <= '0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ack_q <= bus_access;
            if (bus_rd) dat_q <= rd_data;
            if (bus_wr && (wb_adr_i == 2'd2) && !busy_eff) div_q <= wb_dat_i[7:0];
            if (bus_wr && (wb_adr_i == 2'd3)) cs_q <= wb_dat_i[NUM_CS-1:0];
            if (finish) rx_q <= rx_sh_q;
            // A DONE set on the same edge as a DATA read wins.
            if (finish)                                done_q <= 1'b1;
            else if (bus_rd && (wb_adr_i == 2'd0))     done_q <= 1'b0;
            if (bus_wr && (wb_adr_i == 2'd0) && busy_eff)              ovr_q <= 1'b1;
            else if (bus_wr && (wb_adr_i == 2'd1) && wb_dat_i[2])      ovr_q <= 1'b0;
        end
    end

`ifdef WB_SPI_MASTER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (bus_wr && (wb_adr_i == 2'd1)) ie_q <= wb_dat_i[8];
            irq_q <= done_q & ie_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign ie_q = 1'b0;
`endif

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = ~cs_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// Randomized self-checking bench for wb_spi_master with an edge-count reference model,
// plus directed loopback, slave-capture, overrun, reset-abort and (optionally) interrupt scenarios.
module tb_wb_spi_master;

    localparam int NCS = 1;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      wb_adr;
    logic [31:0]     wb_dat_w;
    logic [31:0]     wb_dat_r;
    logic [3:0]      wb_sel;
    logic            wb_we, wb_cyc, wb_stb, wb_ack;
    logic            spi_sck, spi_mosi, spi_miso;
    logic [NCS-1:0]  spi_cs_n;
    logic            irq;

    int n_err = 0;
    int n_chk = 0;

    // MISO source: 0 random, 1 loopback from MOSI, 2 slave shift register
    int          mode = 0;
    logic        miso_rnd = 1'b0;
    logic [7:0]  sl = 8'h00;
    logic [7:0]  cap = 8'h00;

    assign spi_miso = (mode == 1) ? spi_mosi : (mode == 2) ? sl[7] : miso_rnd;

    always #5 clock = ~clock;

    wb_spi_master #(.DIV_RESET(11), .NUM_CS(NCS)) dut (
        .clock      (clock),
        .reset      (reset),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat_w),
        .wb_dat_o   (wb_dat_r),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_ack_o   (wb_ack),
        .spi_sck_o  (spi_sck),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso),
        .spi_cs_n_o (spi_cs_n)
`ifdef WB_SPI_MASTER_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

`ifndef WB_SPI_MASTER_IRQ_EN
    assign irq = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Slave device: captures MOSI on SCK rise, shifts its reply on SCK fall.
    always @(posedge spi_sck) if (mode == 2) cap = {cap[6:0], spi_mosi};
    always @(negedge spi_sck) if (mode == 2) sl = {sl[6:0], 1'b0};

    // Reference model: transfer progress derived from edges elapsed since the start edge.
    int          n = 0;
    logic        m_ack, m_rd, m_busy, m_done, m_ovr, m_ie, m_irq, m_sck, m_mosi;
    logic [7:0]  m_div, m_tx, m_acc, m_rx;
    logic [NCS-1:0] m_cs, m_csn;
    logic [31:0] m_rdata;
    int          m_start, m_D;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ack = 0; m_rd = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_ie = 0; m_irq = 0;
            m_sck = 0; m_mosi = 0; m_div = 8'd11; m_tx = 0; m_acc = 0; m_rx = 0;
            m_cs = '0; m_csn = '1; m_rdata = 0; m_start = 0; m_D = 12;
        end else begin
            logic acc, fin, o_busy, o_done, o_ovr, o_ie;
            logic [7:0] o_rx, o_div;
            logic [NCS-1:0] o_cs;
            int k, ph;
            n++;
            acc = wb_cyc && wb_stb && !m_ack;
            o_busy = m_busy; o_done = m_done; o_ovr = m_ovr; o_ie = m_ie;
            o_rx = m_rx; o_div = m_div; o_cs = m_cs;
            fin = 0;
            if (m_busy) begin
                k = n - m_start;
                if ((k % (2 * m_D)) == m_D) m_acc = {m_acc[6:0], spi_miso};
                if (k == 16 * m_D) begin
                    fin = 1; m_busy = 0; m_rx = m_acc;
                end
            end
            if (acc && wb_we && wb_sel[0]) begin
                case (wb_adr)
                    2'd0: if (!m_busy) begin
                              m_busy = 1; m_start = n; m_tx = wb_dat_w[7:0];
                              m_D = int'(m_div) + 1; m_acc = 0;
                          end else m_ovr = 1;
                    2'd1: begin
                              if (wb_dat_w[2]) m_ovr = 0;
`ifdef WB_SPI_MASTER_IRQ_EN
                              m_ie = wb_dat_w[8];
`endif
                          end
                    2'd2: if (!m_busy) m_div = wb_dat_w[7:0];
                    default: m_cs = wb_dat_w[NCS-1:0];
                endcase
            end
            m_rd = acc && !wb_we;
            if (m_rd) begin
                case (wb_adr)
                    2'd0: m_rdata = {24'd0, o_rx};
                    2'd1: m_rdata = {23'd0, o_ie, 5'd0, o_ovr, o_done, o_busy};
                    2'd2: m_rdata = {24'd0, o_div};
                    default: m_rdata = 32'(o_cs);
                endcase
                if (wb_adr == 2'd0) m_done = 0;
            end
            if (fin) m_done = 1;
            m_irq = o_done & o_ie;
            m_ack = acc;
            m_csn = ~m_cs;
            if (m_busy) begin
                k = n - m_start;
                ph = k / m_D;
                m_sck = ph[0];
                m_mosi = m_tx[7 - ph / 2];
            end else if (fin) begin
                m_sck = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("ack", wb_ack, m_ack);
        chk("sck", spi_sck, m_sck);
        chk("mosi", spi_mosi, m_mosi);
        chk("cs_n", spi_cs_n, m_csn);
        if (m_ack && m_rd) chk("rdata", wb_dat_r, m_rdata);
`ifdef WB_SPI_MASTER_IRQ_EN
        chk("irq", irq, m_irq);
`endif
    end

    initial begin
        forever begin
            @(negedge clock);
            miso_rnd = 1'($urandom);
        end
    end

    task automatic wb(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat);
        int t;
        @(negedge clock);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!wb_ack && t < 8);
        if (!wb_ack) chk("ack_timeout", 32'(wb_ack), 32'd1);
        rdat = wb_dat_r;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic wb_wr(input logic [1:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb(1'b1, adr, dat, 4'hF, d);
    endtask

    task automatic wb_rd(input logic [1:0] adr, output logic [31:0] r);
        wb(1'b0, adr, 32'd0, 4'hF, r);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int t = 0;
        do begin
            wb_rd(2'd1, r);
            t++;
        end while (r[0] && t < 300);
        chk("idle_reached", 32'(r[0]), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int rises, first_r, second_r, last_hi, seen;
        logic prev;
        reset = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat_w = 0; wb_sel = 0;
        repeat (3) @(negedge clock);
        reset = 0;

        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_dat_o", wb_dat_r, 32'd0);
        wb_rd(2'd1, r); chk("rst_status", r, 32'd0);
        wb_rd(2'd2, r); chk("rst_div", r, 32'd11);
        wb_rd(2'd0, r); chk("rst_rx", r, 32'd0);

        // loopback, DIV=0
        wb_wr(2'd2, 32'd0);
        mode = 1;
        wb_wr(2'd0, 32'hA5);
        rises = 0; last_hi = 0; prev = spi_sck;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (spi_sck && !prev) rises++;
            if (spi_sck) last_hi = i;
            prev = spi_sck;
        end
        chk("lb_pulses", 32'(rises), 32'd8);
        chk("lb_last_high", 32'(last_hi), 32'd15);
        wb_rd(2'd1, r); chk("lb_status_done", r, 32'h2);
        wb_rd(2'd0, r); chk("lb_rx", r, 32'hA5);
        wb_rd(2'd1, r); chk("lb_status_clr", r, 32'h0);

        // slave capture, DIV=11
        wb_wr(2'd2, 32'd11);
        mode = 2; sl = 8'h3C; cap = 8'h00;
        wb_wr(2'd0, 32'h81);
        first_r = -1; second_r = -1; prev = spi_sck;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            if (spi_sck && !prev) begin
                if (first_r < 0) first_r = i;
                else if (second_r < 0) second_r = i;
            end
            prev = spi_sck;
        end
        chk("sl_first_rise", 32'(first_r), 32'd12);
        chk("sl_period", 32'(second_r - first_r), 32'd24);
        wait_idle();
        chk("sl_capture", 32'(cap), 32'h81);
        wb_rd(2'd0, r); chk("sl_rx", r, 32'h3C);

        // overrun, DIV write while busy, CS
        sl = 8'h00; cap = 8'h00;
        wb_wr(2'd0, 32'h55);
        wb_rd(2'd1, r); chk("ovr_busy", r, 32'h1);
        wb_wr(2'd0, 32'h66);
        wb_rd(2'd1, r); chk("ovr_set", r, 32'h5);
        wb_wr(2'd2, 32'd3);
        wb_rd(2'd2, r); chk("div_busy_keep", r, 32'd11);
        wb_wr(2'd3, 32'd1);
        @(negedge clock);
        chk("cs_low", 32'(spi_cs_n), 32'd0);
        wait_idle();
        chk("ovr_capture", 32'(cap), 32'h55);
        wb(1'b1, 2'd2, 32'd5, 4'hE, r);
        wb_rd(2'd2, r); chk("div_sel0_ignored", r, 32'd11);
        wb_wr(2'd1, 32'h4);
        wb_rd(2'd1, r); chk("ovr_clear", r, 32'h2);
        wb_rd(2'd0, r); chk("ovr_rx", r, 32'h00);

        // reset during bit 4
        mode = 0;
        wb_wr(2'd0, 32'hC3);
        repeat (9 * 12 - 3) @(negedge clock);
        #2 reset = 1;
        #1;
        chk("abort_sck", 32'(spi_sck), 32'd0);
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        repeat (2) @(negedge clock);
        reset = 0;
        wb_rd(2'd1, r); chk("abort_status", r, 32'd0);
        wb_rd(2'd2, r); chk("abort_div", r, 32'd11);
        wb_rd(2'd0, r); chk("abort_rx", r, 32'd0);

`ifdef WB_SPI_MASTER_IRQ_EN
        wb_wr(2'd2, 32'd0);
        wb_wr(2'd1, 32'h100);
        wb_wr(2'd0, 32'hFF);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clock);
            if (irq) seen = 1;
        end
        chk("irq_rise", 32'(seen), 32'd1);
        wb_rd(2'd1, r); chk("irq_status", r, 32'h102);
        wb_rd(2'd0, r);
        @(negedge clock);
        chk("irq_fall", 32'(irq), 32'd0);
        wb_wr(2'd1, 32'h0);
        wb_wr(2'd0, 32'h0F);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (irq) seen = 1;
        end
        chk("irq_masked", 32'(seen), 32'd0);
        wb_rd(2'd0, r);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            logic        w;
            repeat ($urandom_range(0, 6)) @(negedge clock);
            a = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom);
            w = 1'($urandom);
            d = (a == 2'd2) ? 32'($urandom_range(0, 3)) : $urandom;
            s = ($urandom_range(0, 3) == 0) ? (4'($urandom) & 4'hE) : 4'hF;
            wb(w, a, d, s, r);
        end
        repeat (200) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
